// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared types and helpers for the branch prediction / resolution slice.
//   - btb_entry_t : one direct-mapped BTB line {valid, tag, target, ctr}
//   - CTR_*       : 2-bit direction counter encodings
//   - pc_index / pc_tag : slice a PC into BTB index and tag fields
// No ports (package).
// ---------------------------------------------------------------------------
package branch_pkg;

  // Default geometry; the top module's parameters default to these so the
  // stored tag/target fields line up with the slices taken from the PC.
  localparam int BP_PC_W  = 9;
  localparam int BP_IDX_W = 4;
  localparam int BP_TAG_W = BP_PC_W - BP_IDX_W - 2;

  // Direction counter states: strongly/weakly not-taken, weakly/strongly taken.
  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_PC_W-1:0]  target;
    logic [1:0]          ctr;
  } btb_entry_t;

  // Index field is PC[idx_w+1:2]; instructions are word aligned so the two
  // low bits carry no information.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag field is everything above the index: PC[pc_w-1:idx_w+2].
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int pc_w,
                                         input int idx_w);
    return (pc >> (idx_w + 2)) & ((32'd1 << (pc_w - idx_w - 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Combinational next-state for a 2-bit saturating direction counter.
// Ports:
//   i_ctr  [1:0] current counter value
//   i_up         1 = branch taken (count up), 0 = not taken (count down)
//   o_next [1:0] next counter value, clamped to CTR_SNT..CTR_ST
// ---------------------------------------------------------------------------
module sat_counter
  import branch_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_up,
  output logic [1:0] o_next
);

  // Count toward the resolved direction but hold at either end so a single
  // outlier never flips a strongly biased branch.
  always_comb begin
    o_next = i_ctr;
    if (i_up) begin
      if (i_ctr != CTR_ST) begin
        o_next = i_ctr + 2'd1;
      end
    end else begin
      if (i_ctr != CTR_SNT) begin
        o_next = i_ctr - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
// Execute-stage branch resolution plus a direct-mapped BTB with 2-bit
// direction counters, misprediction redirect and saturating perf counters.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   IF_PC             fetch PC looked up in the BTB
//   Pred_Taken        fetch prediction (hit and counter upper bit set)
//   Pred_Target       predicted target, zero-extended; 0 on miss
//   Ex_Valid          EX stage holds a real instruction
//   Cur_PC, Imm       EX PC and immediate
//   Branch/Jump/Jalr  control-flow kind of the EX instruction
//   AluResult         bit 0 = branch condition; full value = JALR target
//   Ex_Pred_Taken/Ex_Pred_Target  prediction carried down from fetch
//   PC_Imm, PC_Four   resolved taken target and fall-through PC
//   Mispredict        fetch must be redirected to Redirect_PC
//   Br_Cnt, Miss_Cnt  saturating counts of resolved branches / mispredicts
// PC_W must exceed IDX_W+2 so that the tag field is at least one bit wide.
// ---------------------------------------------------------------------------
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_W  = BP_PC_W,
  parameter int IDX_W = BP_IDX_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  IF_PC,
  output logic             Pred_Taken,
  output logic [31:0]      Pred_Target,
  input  logic             Ex_Valid,
  input  logic [PC_W-1:0]  Cur_PC,
  input  logic [31:0]      Imm,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             Jalr,
  input  logic [31:0]      AluResult,
  input  logic             Ex_Pred_Taken,
  input  logic [31:0]      Ex_Pred_Target,
  output logic [31:0]      PC_Imm,
  output logic [31:0]      PC_Four,
  output logic             Mispredict,
  output logic [31:0]      Redirect_PC,
  output logic [CNT_W-1:0] Br_Cnt,
  output logic [CNT_W-1:0] Miss_Cnt
);

  localparam int TAG_W   = PC_W - IDX_W - 2;
  localparam int ENTRIES = 1 << IDX_W;

  btb_entry_t       r_table [ENTRIES];
  logic [CNT_W-1:0] r_brCnt;
  logic [CNT_W-1:0] r_missCnt;

  logic [IDX_W-1:0] w_ifIdx;
  logic [TAG_W-1:0] w_ifTag;
  logic             w_ifHit;
  logic [IDX_W-1:0] w_exIdx;
  logic [TAG_W-1:0] w_exTag;
  logic             w_exHit;
  logic [31:0]      w_pcFull;
  logic [31:0]      w_pcImm;
  logic             w_taken;
  logic             w_ctl;
  logic             w_mispredict;
  logic [1:0]       w_ctrNext;

  // Fetch lookup is a plain asynchronous read of the table, so an update
  // landing on the same index this cycle is only visible after the edge.
  assign w_ifIdx = IDX_W'(pc_index(32'(IF_PC), IDX_W));
  assign w_ifTag = TAG_W'(pc_tag(32'(IF_PC), PC_W, IDX_W));
  assign w_ifHit = r_table[w_ifIdx].valid && (r_table[w_ifIdx].tag == w_ifTag);

  assign Pred_Taken  = w_ifHit && r_table[w_ifIdx].ctr[1];
  assign Pred_Target = w_ifHit ? 32'(r_table[w_ifIdx].target) : 32'd0;

  // Resolution: all 32-bit arithmetic on the zero-extended PC, wrapping.
  assign w_pcFull = 32'(Cur_PC);
  assign w_pcImm  = Jalr ? AluResult : (w_pcFull + Imm);
  assign PC_Imm   = w_pcImm;
  assign PC_Four  = w_pcFull + 32'd4;
  assign w_taken  = (Branch && AluResult[0]) || Jump;
  assign w_ctl    = Ex_Valid && (Branch || Jump);

  // A wrong direction is always a redirect; a wrong target only matters when
  // the instruction actually leaves the fall-through path.
  assign w_mispredict = w_ctl && ((w_taken != Ex_Pred_Taken) ||
                                  (w_taken && (w_pcImm != Ex_Pred_Target)));
  assign Mispredict   = w_mispredict;
  assign Redirect_PC  = w_taken ? w_pcImm : PC_Four;

  // The EX instruction trains the entry selected by its own PC.
  assign w_exIdx = IDX_W'(pc_index(32'(Cur_PC), IDX_W));
  assign w_exTag = TAG_W'(pc_tag(32'(Cur_PC), PC_W, IDX_W));
  assign w_exHit = r_table[w_exIdx].valid && (r_table[w_exIdx].tag == w_exTag);

  sat_counter u_satCounter (
    .i_ctr  (r_table[w_exIdx].ctr),
    .i_up   (w_taken),
    .o_next (w_ctrNext)
  );

  // Table training. Jumps are unconditional, so they pin the counter to
  // strongly taken. A not-taken branch that misses is not worth a line:
  // fetch already falls through on a miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (w_ctl) begin
      if (w_exHit) begin
        if (Jump) begin
          r_table[w_exIdx].ctr    <= CTR_ST;
          r_table[w_exIdx].target <= w_pcImm[PC_W-1:0];
        end else begin
          r_table[w_exIdx].ctr <= w_ctrNext;
          if (w_taken) begin
            r_table[w_exIdx].target <= w_pcImm[PC_W-1:0];
          end
        end
      end else if (w_taken) begin
        r_table[w_exIdx] <= '{valid:  1'b1,
                              tag:    w_exTag,
                              target: w_pcImm[PC_W-1:0],
                              ctr:    (Jump ? CTR_ST : CTR_WT)};
      end
    end
  end

  // Performance counters stick at all-ones instead of wrapping so a long
  // run never reports a misleadingly small value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_brCnt   <= '0;
      r_missCnt <= '0;
    end else begin
      if (w_ctl && (r_brCnt != '1)) begin
        r_brCnt <= r_brCnt + CNT_W'(1);
      end
      if (w_mispredict && (r_missCnt != '1)) begin
        r_missCnt <= r_missCnt + CNT_W'(1);
      end
    end
  end

  assign Br_Cnt   = r_brCnt;
  assign Miss_Cnt = r_missCnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
// Directed stimulus with hand-computed expectations pushed into a queue;
// a monitor on the falling clock edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

  localparam int PC_W  = 9;
  localparam int IDX_W = 4;
  localparam int CNT_W = 16;

  localparam int SEL_PT     = 0;
  localparam int SEL_PTGT   = 1;
  localparam int SEL_MISP   = 2;
  localparam int SEL_REDIR  = 3;
  localparam int SEL_BRCNT  = 4;
  localparam int SEL_MISCNT = 5;
  localparam int SEL_PCIMM  = 6;
  localparam int SEL_PCFOUR = 7;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [PC_W-1:0]  IF_PC;
  logic             Pred_Taken;
  logic [31:0]      Pred_Target;
  logic             Ex_Valid;
  logic [PC_W-1:0]  Cur_PC;
  logic [31:0]      Imm;
  logic             Branch;
  logic             Jump;
  logic             Jalr;
  logic [31:0]      AluResult;
  logic             Ex_Pred_Taken;
  logic [31:0]      Ex_Pred_Target;
  logic [31:0]      PC_Imm;
  logic [31:0]      PC_Four;
  logic             Mispredict;
  logic [31:0]      Redirect_PC;
  logic [CNT_W-1:0] Br_Cnt;
  logic [CNT_W-1:0] Miss_Cnt;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .IF_PC          (IF_PC),
    .Pred_Taken     (Pred_Taken),
    .Pred_Target    (Pred_Target),
    .Ex_Valid       (Ex_Valid),
    .Cur_PC         (Cur_PC),
    .Imm            (Imm),
    .Branch         (Branch),
    .Jump           (Jump),
    .Jalr           (Jalr),
    .AluResult      (AluResult),
    .Ex_Pred_Taken  (Ex_Pred_Taken),
    .Ex_Pred_Target (Ex_Pred_Target),
    .PC_Imm         (PC_Imm),
    .PC_Four        (PC_Four),
    .Mispredict     (Mispredict),
    .Redirect_PC    (Redirect_PC),
    .Br_Cnt         (Br_Cnt),
    .Miss_Cnt       (Miss_Cnt)
  );

  // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SEL_PT:     return 32'(Pred_Taken);
      SEL_PTGT:   return Pred_Target;
      SEL_MISP:   return 32'(Mispredict);
      SEL_REDIR:  return Redirect_PC;
      SEL_BRCNT:  return 32'(Br_Cnt);
      SEL_MISCNT: return 32'(Miss_Cnt);
      SEL_PCIMM:  return PC_Imm;
      SEL_PCFOUR: return PC_Four;
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: everything queued during this half cycle is compared at the
  // falling edge, well away from the register update.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (expQ.size() > 0) begin
      e   = expQ.pop_front();
      act = pick(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s actual=0x%0h required=0x%0h", e.name, act, e.exp);
      end
    end
  end

  task automatic checkOutput(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic v, input logic [PC_W-1:0] pc,
                               input logic [31:0] imm, input logic br,
                               input logic jmp, input logic jalr,
                               input logic [31:0] alu, input logic pt,
                               input logic [31:0] ptgt);
    Ex_Valid       = v;
    Cur_PC         = pc;
    Imm            = imm;
    Branch         = br;
    Jump           = jmp;
    Jalr           = jalr;
    AluResult      = alu;
    Ex_Pred_Taken  = pt;
    Ex_Pred_Target = ptgt;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 9'h000, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCounts(input logic [31:0] br, input logic [31:0] miss, input string tag);
    checkOutput(SEL_BRCNT, br, {tag, "_brcnt"});
    checkOutput(SEL_MISCNT, miss, {tag, "_misscnt"});
  endtask

  task automatic checkPred(input logic [31:0] pt, input logic [31:0] ptgt, input string tag);
    checkOutput(SEL_PT, pt, {tag, "_predtaken"});
    checkOutput(SEL_PTGT, ptgt, {tag, "_predtarget"});
  endtask

  initial begin
    reset = 1'b1;
    IF_PC = 9'h040;
    idle();
    nextCycle();
    reset = 1'b0;

    // Reset state
    checkPred(0, 32'h0, "reset");
    checkCounts(0, 0, "reset");
    checkOutput(SEL_MISP, 0, "reset_misp");
    checkOutput(SEL_PCFOUR, 32'h4, "reset_pcfour");
    nextCycle();

    // First taken branch at 0x040 predicted not-taken: allocate, ctr=WT
    applyStimulus(1, 9'h040, 32'h20, 1, 0, 0, 32'd1, 0, 32'h0);
    checkOutput(SEL_MISP, 1, "first_misp");
    checkOutput(SEL_REDIR, 32'h060, "first_redir");
    checkOutput(SEL_PCIMM, 32'h060, "first_pcimm");
    checkOutput(SEL_PCFOUR, 32'h044, "first_pcfour");
    checkPred(0, 32'h0, "first_nobypass");
    nextCycle();

    idle();
    checkPred(1, 32'h060, "alloc");
    checkCounts(1, 1, "alloc");
    nextCycle();

    // Three correctly predicted taken resolutions: ctr 2 -> 3 -> 3 -> 3
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 9'h040, 32'h20, 1, 0, 0, 32'd1, 1, 32'h060);
      checkOutput(SEL_MISP, 0, "train_taken_misp");
      nextCycle();
    end
    idle();
    checkCounts(4, 1, "train");
    nextCycle();

    // Not taken once: ctr 3 -> 2, still predicts taken
    applyStimulus(1, 9'h040, 32'h20, 1, 0, 0, 32'd0, 1, 32'h060);
    checkOutput(SEL_MISP, 1, "nt1_misp");
    checkOutput(SEL_REDIR, 32'h044, "nt1_redir");
    nextCycle();
    idle();
    checkPred(1, 32'h060, "nt1");
    checkCounts(5, 2, "nt1");
    nextCycle();

    // Not taken again: ctr 2 -> 1, prediction flips; target kept
    applyStimulus(1, 9'h040, 32'h20, 1, 0, 0, 32'd0, 1, 32'h060);
    checkOutput(SEL_MISP, 1, "nt2_misp");
    nextCycle();
    idle();
    checkPred(0, 32'h060, "nt2");
    checkCounts(6, 3, "nt2");
    nextCycle();

    // Alias: 0x080 shares index 0 with tag 2
    IF_PC = 9'h080;
    checkPred(0, 32'h0, "alias_miss");
    nextCycle();

    applyStimulus(1, 9'h080, 32'h100, 0, 1, 0, 32'd0, 0, 32'h0);
    checkOutput(SEL_MISP, 1, "jal_misp");
    checkOutput(SEL_REDIR, 32'h180, "jal_redir");
    checkPred(0, 32'h0, "jal_nobypass");
    nextCycle();

    idle();
    checkPred(1, 32'h180, "alias_replaced");
    checkCounts(7, 4, "jal");
    nextCycle();

    IF_PC = 9'h040;
    checkPred(0, 32'h0, "alias_evicted");
    nextCycle();

    // JALR with Ex_Valid=0: purely combinational outputs, no training
    applyStimulus(0, 9'h010, 32'h0, 0, 1, 1, 32'h1A4, 1, 32'h100);
    checkOutput(SEL_MISP, 0, "jalr_bubble_misp");
    checkOutput(SEL_REDIR, 32'h1A4, "jalr_bubble_redir");
    checkOutput(SEL_PCIMM, 32'h1A4, "jalr_bubble_pcimm");
    nextCycle();

    idle();
    IF_PC = 9'h010;
    checkPred(0, 32'h0, "jalr_bubble_table");
    checkCounts(7, 4, "jalr_bubble");
    nextCycle();

    // JALR valid with wrong predicted target
    applyStimulus(1, 9'h010, 32'h0, 0, 1, 1, 32'h1A4, 1, 32'h100);
    checkOutput(SEL_MISP, 1, "jalr_misp");
    checkOutput(SEL_REDIR, 32'h1A4, "jalr_redir");
    checkOutput(SEL_PCFOUR, 32'h014, "jalr_pcfour");
    nextCycle();

    idle();
    checkPred(1, 32'h1A4, "jalr_alloc");
    checkCounts(8, 5, "jalr");
    nextCycle();

    // Saturate both counters: not-taken branch at 0x100 predicted taken
    // mispredicts every cycle and never allocates.
    applyStimulus(1, 9'h100, 32'h0, 1, 0, 0, 32'd0, 1, 32'h0);
    for (int k = 0; k < 65530; k++) begin
      nextCycle();
    end
    idle();
    checkCounts(32'hFFFF, 32'hFFFF, "sat");
    nextCycle();

    applyStimulus(1, 9'h100, 32'h0, 1, 0, 0, 32'd0, 1, 32'h0);
    checkOutput(SEL_MISP, 1, "sat_extra_misp");
    nextCycle();
    idle();
    checkCounts(32'hFFFF, 32'hFFFF, "sat_hold");
    nextCycle();

    // Reset mid-cycle while an update is pending
    IF_PC = 9'h080;
    applyStimulus(1, 9'h100, 32'h0, 1, 0, 0, 32'd0, 1, 32'h0);
    checkPred(1, 32'h180, "prereset");
    nextCycle();
    #1;
    reset = 1'b1;
    checkPred(0, 32'h0, "midreset");
    checkCounts(0, 0, "midreset");
    checkOutput(SEL_MISP, 1, "midreset_misp");
    checkOutput(SEL_REDIR, 32'h104, "midreset_redir");
    nextCycle();
    reset = 1'b0;
    idle();
    checkPred(0, 32'h0, "postreset");
    checkCounts(0, 0, "postreset");
    nextCycle();
    nextCycle();

    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d required=0 pending expectations", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Branch resolution unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It keeps the execute-stage target and PcSel computation and adds these functions:
- fetch-stage prediction;
- misprediction detection and redirect;
- table training;
- saturating performance counters.
It sits between the IF stage (prediction lookup) and the EX stage (resolution and update).

Parameters:
PC_W, 9, PC width in bits
IDX_W, 4, BTB index bits; 2**IDX_W entries; PC_W > IDX_W+2 is required
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
IF_PC  in  PC_W  fetch PC for lookup
Pred_Taken  out  1  fetch prediction: taken
Pred_Target  out  32  fetch predicted target, zero-extended from PC_W
Ex_Valid  in  1  EX stage holds a real instruction (0 = bubble/flushed)
Cur_PC  in  PC_W  EX-stage PC
Imm  in  32  immediate
Branch  in  1  conditional branch
Jump  in  1  JAL or JALR
Jalr  in  1  JALR (target = AluResult)
AluResult  in  32  branch compare result in bit 0; JALR target
Ex_Pred_Taken  in  1  prediction piped from IF for this instruction
Ex_Pred_Target  in  32  predicted target piped from IF
PC_Imm  out  32  resolved target
PC_Four  out  32  Cur_PC+4, zero-extended
Mispredict  out  1  redirect required
Redirect_PC  out  32  PC to fetch on mispredict
Br_Cnt  out  CNT_W  resolved control-flow instructions
Miss_Cnt  out  CNT_W  mispredictions

Behaviour:
- Index = PC[IDX_W+1:2]; tag = PC[PC_W-1:IDX_W+2].
- Each entry holds: valid, tag, target[PC_W-1:0], ctr[1:0].
- Lookup is combinational (asynchronous read):
  - hit = valid && tag match.
  - Pred_Taken = hit && ctr[1].
  - Pred_Target = hit ? {0, target} : 0.
- Resolution is combinational on EX inputs:
  - PC_Full = zero-extended Cur_PC.
  - PC_Imm = Jalr ? AluResult : PC_Full+Imm. Arithmetic is 32-bit and wraps.
  - PC_Four = PC_Full+4.
  - taken = (Branch && AluResult[0]) || Jump.
- Misprediction detection:
  - ctl = Ex_Valid && (Branch || Jump).
  - Mispredict = ctl && ((taken != Ex_Pred_Taken) || (taken && PC_Imm != Ex_Pred_Target)).
  - Redirect_PC = taken ? PC_Imm : PC_Four.
  - Mispredict = 0 whenever Ex_Valid = 0, regardless of other inputs.
- Update happens on the rising clk edge when ctl = 1, at the entry addressed by Cur_PC:
  - Hit, Branch: ctr increments if taken, decrements if not; saturates at 3 and 0. Target <= PC_Imm[PC_W-1:0] if taken.
  - Hit, Jump: ctr <= 3; target <= PC_Imm[PC_W-1:0].
  - Miss, taken (Branch or Jump): allocate. valid=1, tag written, target written; ctr = 2 for Branch, 3 for Jump.
  - Miss, Branch not taken: no allocation; table unchanged.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents. There is no bypass.
- Performance counters:
  - Br_Cnt increments each cycle ctl = 1.
  - Miss_Cnt increments each cycle Mispredict = 1.
  - Both saturate at all-ones and never wrap.
- Reset, asynchronous, at any time including mid-update:
  - all valid = 0;
  - all ctr = 1 (weakly not-taken);
  - targets and tags = 0;
  - Br_Cnt = Miss_Cnt = 0.
  - Result: Pred_Taken = 0 and Pred_Target = 0 immediately. Combinational EX outputs follow their inputs.
- No sequential state other than the table and the two counters. Resolution latency is 0 cycles; training latency is 1 edge.

Decomposition:
- Package branch_pkg holds:
  - btb_entry_t packed struct {valid, tag, target, ctr};
  - counter constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3;
  - index/tag slice helper functions parametrised on PC_W and IDX_W.
- One sub-module, sat_counter: 2-bit saturating increment/decrement, combinational next-state.
- The table array and performance counters stay in the top module.

Test Plan:
- After reset, IF_PC=0x040 -> Pred_Taken=0, Pred_Target=0; Br_Cnt=0, Miss_Cnt=0.
- EX: Branch=1, Cur_PC=0x040, Imm=0x20, AluResult=1, Ex_Pred_Taken=0, Ex_Valid=1 -> same cycle Mispredict=1, Redirect_PC=0x060. Then next cycle IF_PC=0x040 -> Pred_Taken=1, Pred_Target=0x060; Br_Cnt=1, Miss_Cnt=1.
- Resolve PC 0x040 taken three more times -> ctr=3. Then resolve not-taken once -> ctr=2 and Pred_Taken stays 1. Resolve not-taken again -> ctr=1 and Pred_Taken=0.
- Alias: PC 0x080 has the same index as 0x040 with tag 2. Allocate 0x040 (tag 1) first, then IF_PC=0x080 -> Pred_Taken=0 (tag miss). Resolve a taken Jump at 0x080 -> entry replaced, ctr=3; IF_PC=0x040 now misses.
- JALR at Cur_PC=0x010, AluResult=0x1A4, Ex_Pred_Taken=1, Ex_Pred_Target=0x100 -> Mispredict=1, Redirect_PC=0x1A4. With Ex_Valid=0 and the same inputs -> Mispredict=0 and no table or counter change.
- Force Miss_Cnt to 0xFFFF (CNT_W=16) via repeated mispredicts, then apply one more mispredict -> Miss_Cnt holds 0xFFFF. Assert reset mid-cycle -> all outputs and counters clear asynchronously.
